updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
Parametrised up/down modulo-N counter that generalises single-bit toggle storage to a WIDTH-bit count. It adds direction control, synchronous load and clear, wrap or saturate modes, and terminal-count and wrap status. It is the standard event, timer and divider counter for sequential designs in this codebase.

Parameters:
WIDTH, 8, counter width in bits.
MODULUS, 256, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
en  input  1  count enable; step by one this cycle.
up  input  1  direction: 1 = increment, 0 = decrement.
clr  input  1  synchronous clear to 0.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  value to load.
count  output  WIDTH  registered current count.
tc  output  1  combinational terminal count.
wrap  output  1  registered one-cycle pulse on wrap or saturation hit.
ovf  output  1  registered sticky flag, set on any wrap or saturation hit.

Behaviour:
- Reset (asynchronous, rst=1): count=0, wrap=0, ovf=0, immediately and independent of clk. Release takes effect on the next rising edge; no count change on the release edge unless the controls request one.
- Per-edge priority, highest first: clr > load > en > hold.
- clr=1: count<=0, wrap<=0, ovf<=0. load and en are ignored.
- load=1 (clr=0): count<=load_val. If load_val >= MODULUS, count<=MODULUS-1 (clamp). wrap<=0. ovf unchanged. en is ignored.
- en=1, up=1, count<MODULUS-1: count<=count+1, wrap<=0.
- en=1, up=1, count==MODULUS-1:
  - SATURATE=0: count<=0.
  - SATURATE=1: count holds.
  - Either mode: wrap<=1, ovf<=1.
- en=1, up=0, count>0: count<=count-1, wrap<=0.
- en=1, up=0, count==0:
  - SATURATE=0: count<=MODULUS-1.
  - SATURATE=1: count holds at 0.
  - Either mode: wrap<=1, ovf<=1.
- en=0 (no clr, no load): count holds, wrap<=0, ovf holds.
- wrap is high for exactly one cycle per terminal event. With SATURATE=1 and en held at a boundary, wrap re-asserts on every enabled edge.
- tc = en & ((up & count==MODULUS-1) | (~up & count==0)). It is combinational, so it is valid in the cycle before the wrap edge and can be used to cascade counters.
- Arithmetic is modulo MODULUS and never leaves the range 0..MODULUS-1. When MODULUS = 2**WIDTH, natural binary overflow is permitted, but the explicit compare still drives wrap.
- Direction change while en=1 takes effect on the same edge; there is no pipeline delay.
- Latency: one clock edge from control input to count and wrap.
- If rst asserts mid-count, all state clears asynchronously. No partial update is permitted.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0. Reset, then en=1, up=1 for 12 edges -> count goes 1..9, 0, 1, 2. wrap is high only after the edge where 9->0. tc=1 while count=9. ovf=1 from then on.
2. Same config, up=0 from count=0, en=1 for 3 edges -> count goes 9, 8, 7. wrap pulses once after 0->9. tc=1 while count=0 and up=0.
3. SATURATE=1, MODULUS=10, count=9, up=1, en=1 held for 3 edges -> count stays at 9. wrap=1 on all 3 cycles. ovf=1.
4. Priority: at count=5, drive clr=1, load=1, load_val=3, en=1 together -> count=0, ovf=0. Next edge with load=1, load_val=12 (MODULUS=10) -> count=9 (clamped), wrap=0.
5. Async reset: assert rst mid-cycle while count=7, away from any clk edge -> count=0, wrap=0, ovf=0 before the next edge. Deassert rst, then en=1 -> count=1 after the next edge.
6. WIDTH=8, MODULUS=256: count from 254 with en=1, up=1 -> count goes 255, 0. wrap pulses once. en=0 for 3 cycles -> count holds at 0, wrap=0, tc=0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with synchronous clear/load, wrap or saturate
// at the range ends, a combinational terminal count and registered wrap/overflow status.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam int unsigned     EXT_W   = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULUS);
    localparam logic             SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             ovf_next;
    logic             at_max;
    logic             at_zero;
    logic             load_over;

    assign at_max    = (count == MAX_VAL);
    assign at_zero   = (count == '0);
    // Compare one bit wider so MODULUS == 2**WIDTH never clamps.
    assign load_over = ({1'b0, load_val} >= MOD_EXT);

    // Valid in the cycle before the terminal edge, for cascading.
    assign tc = en & ((up & at_max) | (~up & at_zero));

    // Next-state selection: clr > load > en > hold.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        ovf_next   = ovf;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next = load_over ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    count_next = SAT ? count : '0;
                    wrap_next  = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_next = SAT ? count : MAX_VAL;
                    wrap_next  = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: three instances (mod-10 wrap,
// mod-10 saturate, mod-256 wrap) driven by directed vectors.
module tb_updown_mod_counter;

    typedef struct {
        int         dut;
        logic [7:0] count;
        logic       wrap;
        logic       ovf;
        string      nm;
    } st_t;

    typedef struct {
        int    dut;
        logic  tc;
        string nm;
    } tc_t;

    logic clk;
    logic rst;
    logic       en_v   [3];
    logic       up_v   [3];
    logic       clr_v  [3];
    logic       load_v [3];
    logic [7:0] lv_v   [3];

    logic [3:0] c0, c1;
    logic [7:0] c2;
    logic       t0, t1, t2;
    logic       w0, w1, w2;
    logic       o0, o1, o2;

    st_t  st_q[$];
    st_t  now_q[$];
    tc_t  tc_q[$];
    event chk_now;
    int   errors;
    int   checks;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap10 (
        .clk(clk), .rst(rst), .en(en_v[0]), .up(up_v[0]), .clr(clr_v[0]),
        .load(load_v[0]), .load_val(lv_v[0][3:0]),
        .count(c0), .tc(t0), .wrap(w0), .ovf(o0)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat10 (
        .clk(clk), .rst(rst), .en(en_v[1]), .up(up_v[1]), .clr(clr_v[1]),
        .load(load_v[1]), .load_val(lv_v[1][3:0]),
        .count(c1), .tc(t1), .wrap(w1), .ovf(o1)
    );

    updown_mod_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u_wrap256 (
        .clk(clk), .rst(rst), .en(en_v[2]), .up(up_v[2]), .clr(clr_v[2]),
        .load(load_v[2]), .load_val(lv_v[2]),
        .count(c2), .tc(t2), .wrap(w2), .ovf(o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {count, wrap, ovf, tc} of the selected instance
    function automatic logic [10:0] obs(input int d);
        case (d)
            0:       obs = {4'b0, c0, w0, o0, t0};
            1:       obs = {4'b0, c1, w1, o1, t1};
            default: obs = {c2, w2, o2, t2};
        endcase
    endfunction

    task automatic check(input string nm, input string field,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, field, act, exp, $time);
        end
    endtask

    task automatic check_state(input st_t e);
        logic [10:0] o;
        o = obs(e.dut);
        check(e.nm, "count", o[10:3], e.count);
        check(e.nm, "wrap", 8'(o[2]), 8'(e.wrap));
        check(e.nm, "ovf", 8'(o[1]), 8'(e.ovf));
    endtask

    task automatic drive(input int d, input logic e, input logic u, input logic c,
                         input logic l, input logic [7:0] lv);
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; up_v[i] = 1'b0; clr_v[i] = 1'b0; load_v[i] = 1'b0; lv_v[i] = 8'd0;
        end
        if (d >= 0) begin
            en_v[d] = e; up_v[d] = u; clr_v[d] = c; load_v[d] = l; lv_v[d] = lv;
        end
    endtask

    // One vector: inputs applied just after an edge, tc expected before the
    // next edge, state expected after it.
    task automatic vec(input int d, input logic e, input logic u, input logic c,
                       input logic l, input logic [7:0] lv, input logic etc,
                       input logic [7:0] ec, input logic ew, input logic eo,
                       input string nm);
        tc_t tv;
        st_t sv;
        @(posedge clk);
        #1;
        drive(d, e, u, c, l, lv);
        tv.dut = d; tv.tc = etc; tv.nm = nm;
        sv.dut = d; sv.count = ec; sv.wrap = ew; sv.ovf = eo; sv.nm = nm;
        tc_q.push_back(tv);
        st_q.push_back(sv);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        drive(-1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic push_now(input int d, input string nm);
        st_t sv;
        sv.dut = d; sv.count = 8'd0; sv.wrap = 1'b0; sv.ovf = 1'b0; sv.nm = nm;
        now_q.push_back(sv);
    endtask

    // Clocked monitor: state of the previous vector, then tc of the current one.
    initial begin
        bit inflight;
        inflight = 1'b0;
        forever begin
            @(negedge clk);
            if (inflight) begin
                if (st_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: state queue empty, got 0 entries expected 1");
                end else begin
                    check_state(st_q.pop_front());
                end
            end
            inflight = 1'b0;
            if (tc_q.size() > 0) begin
                tc_t tv;
                tv = tc_q.pop_front();
                check(tv.nm, "tc", 8'(obs(tv.dut)[0]), 8'(tv.tc));
                inflight = 1'b1;
            end
        end
    end

    // Asynchronous monitor for checks that must hold between edges.
    initial begin
        forever begin
            @(chk_now);
            while (now_q.size() > 0) check_state(now_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_cnt [12];
        logic [11:0] t1_tc;
        logic [11:0] t1_wr;
        logic [11:0] t1_ov;
        int waited;

        t1_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
        t1_tc  = 12'b0010_0000_0000;
        t1_wr  = 12'b0010_0000_0000;
        t1_ov  = 12'b1110_0000_0000;
        errors = 0;
        checks = 0;

        rst = 1'b1;
        drive(-1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #3;
        push_now(0, "reset0");
        push_now(1, "reset1");
        push_now(2, "reset2");
        -> chk_now;
        @(negedge clk);
        rst = 1'b0;

        // Count up through the mod-10 wrap
        for (int i = 0; i < 12; i++)
            vec(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, t1_tc[i], t1_cnt[i], t1_wr[i], t1_ov[i], "up_wrap");

        // Clear, then count down through zero
        vec(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, "clr");
        vec(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1, "down_wrap");
        vec(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd8, 1'b0, 1'b1, "down8");
        vec(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd7, 1'b0, 1'b1, "down7");

        // Saturating instance holds at both ends, wrap on every enabled edge
        vec(1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 8'd9, 1'b0, 1'b0, "sat_load9");
        vec(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1, "sat_hi1");
        vec(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1, "sat_hi2");
        vec(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1, "sat_hi3");
        vec(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd9, 1'b0, 1'b1, "sat_hold");
        vec(1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, "sat_load0");
        vec(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b1, "sat_lo");

        // Full-range binary counter wraps 255 -> 0, then holds
        vec(2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd254, 1'b0, 8'd254, 1'b0, 1'b0, "w8_load");
        vec(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd255, 1'b0, 1'b0, "w8_255");
        vec(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b1, "w8_wrap");
        vec(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, "w8_hold1");
        vec(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, "w8_hold2");
        vec(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, "w8_hold3");

        // Priority clr > load > en, and load clamp
        vec(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0, 1'b1, "load5");
        vec(0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, "prio_clr");
        vec(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd12, 1'b0, 8'd9, 1'b0, 1'b0, "load_clamp");

        // Set ovf, sit at 7, then reset between edges
        vec(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b1, "wrap_again");
        vec(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 8'd7, 1'b0, 1'b1, "load7");
        idle();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        push_now(0, "async_rst");
        -> chk_now;
        #1;
        rst = 1'b0;
        vec(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, "post_rst");

        idle();
        waited = 0;
        while ((st_q.size() > 0 || tc_q.size() > 0) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (st_q.size() != 0 || tc_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", st_q.size() + tc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
